char_buffer_writer: RTL and testbench



---
 rtl/char_buffer_writer.sv | 249 ++++++++++++++++++++++++
 tb/tb_char_buffer_writer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_buffer_writer.sv
// VT52-subset command stage: decodes received bytes into character buffer writes and circular-scroll
// origin updates. Define CLEAR_ON_RESET_EN to blank the whole screen after every reset.
module char_buffer_writer #(
  parameter int COLUMNS   = 80,
  parameter int ROWS      = 25,
  parameter int ROW_BITS  = 5,
  parameter int COL_BITS  = 7,
  parameter int ADDR_BITS = 11
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [7:0]           data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic [ADDR_BITS-1:0] buffer_waddr,
  output logic [7:0]           buffer_din,
  output logic                 buffer_wen,
  output logic [ADDR_BITS-1:0] buffer_first_char,
  output logic                 buffer_first_char_wen,
  output logic [ROW_BITS-1:0]  cursor_row,
  output logic [COL_BITS-1:0]  cursor_col
);

  localparam int CNT_BITS = $clog2(ROWS * COLUMNS + 1);

  localparam logic [ROW_BITS-1:0]  ROW_MAX    = ROW_BITS'(ROWS - 1);
  localparam logic [COL_BITS-1:0]  COL_MAX    = COL_BITS'(COLUMNS - 1);
  localparam logic [ADDR_BITS-1:0] COLS_A     = ADDR_BITS'(COLUMNS);
  localparam logic [ADDR_BITS-1:0] BOTTOM_OFF = ADDR_BITS'((ROWS - 1) * COLUMNS);
  localparam logic [CNT_BITS-1:0]  COLS_C     = CNT_BITS'(COLUMNS);
  localparam logic [7:0]           BLANK      = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    ESC,
    ESC_Y_ROW,
    ESC_Y_COL,
    FILL,
    SCROLL
  } state_t;

`ifdef CLEAR_ON_RESET_EN
  localparam state_t               RST_STATE = FILL;
  localparam logic [CNT_BITS-1:0]  RST_REM   = CNT_BITS'(ROWS * COLUMNS);
`else
  localparam state_t               RST_STATE = IDLE;
  localparam logic [CNT_BITS-1:0]  RST_REM   = '0;
`endif

  state_t               state_q, state_d;
  logic                 ready_q, ready_d;
  logic                 wen_q, wen_d;
  logic                 fc_wen_q, fc_wen_d;
  logic [ADDR_BITS-1:0] waddr_q, waddr_d;
  logic [7:0]           din_q, din_d;
  logic [ADDR_BITS-1:0] first_char_q, first_char_d;
  logic [ROW_BITS-1:0]  row_q, row_d;
  logic [COL_BITS-1:0]  col_q, col_d;
  logic [ROW_BITS-1:0]  y_row_q, y_row_d;
  logic [ADDR_BITS-1:0] fill_addr_q, fill_addr_d;
  logic [CNT_BITS-1:0]  rem_q, rem_d;

  logic                 accept;
  logic [ADDR_BITS-1:0] cur_addr;
  logic [CNT_BITS-1:0]  eos_cnt;
  logic [CNT_BITS-1:0]  eol_cnt;

  function automatic logic [ROW_BITS-1:0] clamp_row(input logic [7:0] b);
    logic [7:0] v;
    v = b - 8'h20;
    if (b < 8'h20) return '0;
    if (v > 8'(ROWS - 1)) return ROW_MAX;
    return ROW_BITS'(v);
  endfunction

  function automatic logic [COL_BITS-1:0] clamp_col(input logic [7:0] b);
    logic [7:0] v;
    v = b - 8'h20;
    if (b < 8'h20) return '0;
    if (v > 8'(COLUMNS - 1)) return COL_MAX;
    return COL_BITS'(v);
  endfunction

  // Next multiple of 8 strictly above col, computed one bit wider so it cannot wrap.
  function automatic logic [COL_BITS-1:0] tab_stop(input logic [COL_BITS-1:0] c);
    logic [COL_BITS:0] t;
    t = ({1'b0, c} | (COL_BITS + 1)'(7)) + (COL_BITS + 1)'(1);
    if (t > {1'b0, COL_MAX}) return COL_MAX;
    return COL_BITS'(t);
  endfunction

  assign accept   = data_valid && ready_q;
  assign cur_addr = first_char_q + ADDR_BITS'(row_q) * COLS_A + ADDR_BITS'(col_q);
  assign eol_cnt  = COLS_C - CNT_BITS'(col_q);
  assign eos_cnt  = (CNT_BITS'(ROW_MAX) - CNT_BITS'(row_q)) * COLS_C + eol_cnt;

  always_comb begin
    state_d      = state_q;
    wen_d        = 1'b0;
    fc_wen_d     = 1'b0;
    waddr_d      = waddr_q;
    din_d        = din_q;
    first_char_d = first_char_q;
    row_d        = row_q;
    col_d        = col_q;
    y_row_d      = y_row_q;
    fill_addr_d  = fill_addr_q;
    rem_d        = rem_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (data_in >= 8'h20 && data_in <= 8'h7E) begin
            wen_d   = 1'b1;
            waddr_d = cur_addr;
            din_d   = data_in;
            if (col_q != COL_MAX) col_d = col_q + COL_BITS'(1);
          end else begin
            case (data_in)
              8'h0D: col_d = '0;
              8'h08: if (col_q != '0) col_d = col_q - COL_BITS'(1);
              8'h09: col_d = tab_stop(col_q);
              8'h0A: begin
                if (row_q != ROW_MAX) begin
                  row_d = row_q + ROW_BITS'(1);
                end else begin
                  state_d      = SCROLL;
                  first_char_d = first_char_q + COLS_A;
                  fc_wen_d     = 1'b1;
                end
              end
              8'h1B:   state_d = ESC;
              default: ;
            endcase
          end
        end
      end

      ESC: begin
        if (accept) begin
          state_d = IDLE;
          case (data_in)
            "A": if (row_q != '0) row_d = row_q - ROW_BITS'(1);
            "B": if (row_q != ROW_MAX) row_d = row_q + ROW_BITS'(1);
            "C": if (col_q != COL_MAX) col_d = col_q + COL_BITS'(1);
            "D": if (col_q != '0) col_d = col_q - COL_BITS'(1);
            "H": begin
              row_d = '0;
              col_d = '0;
            end
            "J", "K": begin
              // The first blank goes out with the command itself; FILL issues the remainder.
              state_d     = FILL;
              wen_d       = 1'b1;
              waddr_d     = cur_addr;
              din_d       = BLANK;
              fill_addr_d = cur_addr + ADDR_BITS'(1);
              rem_d       = ((data_in == "J") ? eos_cnt : eol_cnt) - CNT_BITS'(1);
            end
            "Y":     state_d = ESC_Y_ROW;
            default: ;
          endcase
        end
      end

      ESC_Y_ROW: begin
        if (accept) begin
          y_row_d = clamp_row(data_in);
          state_d = ESC_Y_COL;
        end
      end

      ESC_Y_COL: begin
        if (accept) begin
          row_d   = y_row_q;
          col_d   = clamp_col(data_in);
          state_d = IDLE;
        end
      end

      FILL: begin
        if (rem_q != '0) begin
          wen_d       = 1'b1;
          waddr_d     = fill_addr_q;
          din_d       = BLANK;
          fill_addr_d = fill_addr_q + ADDR_BITS'(1);
          rem_d       = rem_q - CNT_BITS'(1);
        end else begin
          state_d = IDLE;
        end
      end

      SCROLL: begin
        // Origin has already advanced; blank the row that just wrapped into the bottom line.
        state_d     = FILL;
        wen_d       = 1'b1;
        waddr_d     = first_char_q + BOTTOM_OFF;
        din_d       = BLANK;
        fill_addr_d = first_char_q + BOTTOM_OFF + ADDR_BITS'(1);
        rem_d       = COLS_C - CNT_BITS'(1);
      end

      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE) || (state_d == ESC) ||
              (state_d == ESC_Y_ROW) || (state_d == ESC_Y_COL);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= RST_STATE;
      ready_q      <= 1'b0;
      wen_q        <= 1'b0;
      fc_wen_q     <= 1'b0;
      waddr_q      <= '0;
      din_q        <= '0;
      first_char_q <= '0;
      row_q        <= '0;
      col_q        <= '0;
      y_row_q      <= '0;
      fill_addr_q  <= '0;
      rem_q        <= RST_REM;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      wen_q        <= wen_d;
      fc_wen_q     <= fc_wen_d;
      waddr_q      <= waddr_d;
      din_q        <= din_d;
      first_char_q <= first_char_d;
      row_q        <= row_d;
      col_q        <= col_d;
      y_row_q      <= y_row_d;
      fill_addr_q  <= fill_addr_d;
      rem_q        <= rem_d;
    end
  end

  assign data_ready            = ready_q;
  assign buffer_waddr          = waddr_q;
  assign buffer_din            = din_q;
  assign buffer_wen            = wen_q;
  assign buffer_first_char     = first_char_q;
  assign buffer_first_char_wen = fc_wen_q;
  assign cursor_row            = row_q;
  assign cursor_col            = col_q;

endmodule

// File: tb/tb_char_buffer_writer.sv
// Scoreboard bench for char_buffer_writer: a byte-level reference model queues expected writes and
// origin loads as bytes are driven; a negedge monitor pops and compares them as the DUT emits them.
module tb_char_buffer_writer;
  localparam int COLUMNS   = 80;
  localparam int ROWS      = 25;
  localparam int ROW_BITS  = 5;
  localparam int COL_BITS  = 7;
  localparam int ADDR_BITS = 11;
  localparam int BOUND     = 5000;

  logic                 clk = 1'b0;
  logic                 clr = 1'b1;
  logic [7:0]           data_in = 8'h00;
  logic                 data_valid = 1'b0;
  logic                 data_ready;
  logic [ADDR_BITS-1:0] buffer_waddr;
  logic [7:0]           buffer_din;
  logic                 buffer_wen;
  logic [ADDR_BITS-1:0] buffer_first_char;
  logic                 buffer_first_char_wen;
  logic [ROW_BITS-1:0]  cursor_row;
  logic [COL_BITS-1:0]  cursor_col;

  always #5 clk = ~clk;

  char_buffer_writer #(
    .COLUMNS(COLUMNS), .ROWS(ROWS), .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .ADDR_BITS(ADDR_BITS)
  ) dut (
    .clk(clk), .clr(clr), .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .buffer_waddr(buffer_waddr), .buffer_din(buffer_din), .buffer_wen(buffer_wen),
    .buffer_first_char(buffer_first_char), .buffer_first_char_wen(buffer_first_char_wen),
    .cursor_row(cursor_row), .cursor_col(cursor_col)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_ign = 0;
  bit          sb_ignore = 1'b0;
  logic [18:0] exp_w[$];
  logic [10:0] exp_fc[$];
  logic [18:0] mon_w;
  logic [10:0] mon_fc;
  int          m_st, m_row, m_col, m_fc, m_yrow;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  task automatic push_w(input int a, input logic [7:0] d);
    exp_w.push_back({11'(a % 2048), d});
  endtask

  // Reference behaviour of one accepted byte.
  task automatic model_byte(input logic [7:0] b);
    int bi;
    int base;
    bi = int'(b);
    case (m_st)
      0: begin
        if (bi >= 32 && bi <= 126) begin
          push_w(m_fc + m_row * COLUMNS + m_col, b);
          if (m_col < COLUMNS - 1) m_col++;
        end else if (bi == 13) m_col = 0;
        else if (bi == 8) begin
          if (m_col > 0) m_col--;
        end else if (bi == 9) begin
          m_col = (m_col / 8 + 1) * 8;
          if (m_col > COLUMNS - 1) m_col = COLUMNS - 1;
        end else if (bi == 10) begin
          if (m_row < ROWS - 1) m_row++;
          else begin
            m_fc = (m_fc + COLUMNS) % 2048;
            exp_fc.push_back(11'(m_fc));
            for (int i = 0; i < COLUMNS; i++) push_w(m_fc + (ROWS - 1) * COLUMNS + i, 8'h20);
          end
        end else if (bi == 27) m_st = 1;
      end
      1: begin
        m_st = 0;
        base = m_fc + m_row * COLUMNS + m_col;
        case (b)
          "A": if (m_row > 0) m_row--;
          "B": if (m_row < ROWS - 1) m_row++;
          "C": if (m_col < COLUMNS - 1) m_col++;
          "D": if (m_col > 0) m_col--;
          "H": begin m_row = 0; m_col = 0; end
          "J": for (int i = 0; i < (ROWS - 1 - m_row) * COLUMNS + (COLUMNS - m_col); i++)
                 push_w(base + i, 8'h20);
          "K": for (int i = 0; i < COLUMNS - m_col; i++) push_w(base + i, 8'h20);
          "Y": m_st = 2;
          default: ;
        endcase
      end
      2: begin
        m_yrow = (bi < 32) ? 0 : ((bi - 32 > ROWS - 1) ? ROWS - 1 : bi - 32);
        m_st = 3;
      end
      default: begin
        m_row = m_yrow;
        m_col = (bi < 32) ? 0 : ((bi - 32 > COLUMNS - 1) ? COLUMNS - 1 : bi - 32);
        m_st = 0;
      end
    endcase
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (data_ready !== 1'b1 && n < BOUND) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    model_byte(b);
    data_in    = b;
    data_valid = 1'b1;
    wait_ready(n);
    if (n >= BOUND) check_val("ready_wait_bound", 32'(n), 32'(BOUND - 1));
    @(posedge clk); #1;
    data_valid = 1'b0;
  endtask

  task automatic goto_rc(input int r, input int c);
    send(8'h1B); send("Y"); send(8'(r + 32)); send(8'(c + 32));
  endtask

  task automatic check_cursor(input string tag, input int r, input int c);
    check_val({tag, "_row"}, 32'(cursor_row), 32'(r));
    check_val({tag, "_col"}, 32'(cursor_col), 32'(c));
  endtask

  task automatic do_reset();
    int n;
    clr        = 1'b1;
    data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_w.delete();
    exp_fc.delete();
    sb_ignore = 1'b0;
    m_st = 0; m_row = 0; m_col = 0; m_fc = 0; m_yrow = 0;
    check_val("rst_wen", 32'(buffer_wen), 0);
    check_val("rst_fc_wen", 32'(buffer_first_char_wen), 0);
    check_val("rst_waddr", 32'(buffer_waddr), 0);
    check_val("rst_din", 32'(buffer_din), 0);
    check_val("rst_first_char", 32'(buffer_first_char), 0);
    check_val("rst_ready", 32'(data_ready), 0);
    check_cursor("rst", 0, 0);
    clr = 1'b0;
`ifdef CLEAR_ON_RESET_EN
    for (int i = 0; i < ROWS * COLUMNS; i++) push_w(i, 8'h20);
    wait_ready(n);
    check_val("clear_ready_cycles", 32'(n), 32'(ROWS * COLUMNS + 1));
    check_val("clear_drained", 32'(exp_w.size()), 0);
`else
    wait_ready(n);
    check_val("release_ready_cycles", 32'(n), 1);
`endif
  endtask

  always @(negedge clk) begin
    if (!clr) begin
      if (buffer_wen) begin
        check_val("wen_with_fc_wen", 32'(buffer_first_char_wen), 0);
        if (sb_ignore) n_ign++;
        else if (exp_w.size() == 0) check_val("write_expected", 32'(exp_w.size()), 1);
        else begin
          mon_w = exp_w.pop_front();
          check_val("wr_addr", 32'(buffer_waddr), 32'(mon_w[18:8]));
          check_val("wr_data", 32'(buffer_din), 32'(mon_w[7:0]));
        end
      end
      if (buffer_first_char_wen && !sb_ignore) begin
        if (exp_fc.size() == 0) check_val("fc_load_expected", 32'(exp_fc.size()), 1);
        else begin
          mon_fc = exp_fc.pop_front();
          check_val("first_char_load", 32'(buffer_first_char), 32'(mon_fc));
        end
      end
    end
  end

  initial begin
    int n;
    do_reset();

    send("A");
    check_cursor("after_A", 0, 1);
    send("B");
    check_cursor("after_AB", 0, 2);

    // Ignored control byte, unknown escape, then a printable that must land as a write.
    send(8'h07); send(8'h1B); send("Q"); send("C");
    check_cursor("esc_q_ignored", 0, 3);

    goto_rc(5, 10);
    check_cursor("esc_y", 5, 10);
    send("X");
    check_cursor("after_X", 5, 11);

    goto_rc(5, 79);
    send("Z");
    check_cursor("z1_sat", 5, 79);
    send("Z");
    check_cursor("z2_sat", 5, 79);

    goto_rc(5, 3);
    send(8'h08);
    check_cursor("bs", 5, 2);
    send(8'h09);
    check_cursor("tab", 5, 8);
    goto_rc(5, 76);
    send(8'h09);
    check_cursor("tab_cap", 5, 79);
    send(8'h0D);
    check_cursor("cr", 5, 0);

    send(8'h1B); send("H");
    check_cursor("home", 0, 0);
    send(8'h1B); send("A");
    check_cursor("up_clamp", 0, 0);
    send(8'h1B); send("D");
    check_cursor("left_clamp", 0, 0);
    send(8'h1B); send("B");
    send(8'h1B); send("C");
    check_cursor("down_right", 1, 1);
    send(8'h0A);
    check_cursor("lf", 2, 1);

    send(8'h1B); send("Y"); send(8'h7F); send(8'h10);
    check_cursor("y_clamp", 24, 0);
    send(8'h1B); send("B");
    check_cursor("down_clamp", 24, 0);

    goto_rc(24, 78);
    send(8'h1B); send("K");
    wait_ready(n);
    check_val("esc_k_ready_low", 32'(n), 2);
    check_cursor("esc_k", 24, 78);
    check_val("esc_k_drained", 32'(exp_w.size()), 0);

    goto_rc(24, 3);
    send(8'h0A);
    wait_ready(n);
    check_val("scroll_ready_low", 32'(n), 81);
    check_val("scroll_first_char", 32'(buffer_first_char), 80);
    check_cursor("scroll", 24, 3);
    check_val("scroll_drained", 32'(exp_w.size()), 0);
    send("X");

    // Abort a full-screen clear partway through.
    send(8'h1B); send("H");
    sb_ignore = 1'b1;
    send(8'h1B); send("J");
    repeat (98) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk); #1;
    check_val("abort_wen", 32'(buffer_wen), 0);
    check_val("abort_fill_was_running", 32'(n_ign > 90), 1);
    do_reset();
    repeat (30) @(posedge clk);
    #1;
    check_val("post_abort_first_char", 32'(buffer_first_char), 0);
    check_cursor("post_abort", 0, 0);
    check_val("post_abort_ready", 32'(data_ready), 1);

    check_val("wr_queue_empty", 32'(exp_w.size()), 0);
    check_val("fc_queue_empty", 32'(exp_fc.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule
